// File: rtl/traffic_sensor_conditioner.sv
// Front-end conditioning for the traffic controller: synchronises the train detector and
// vehicle loop, stretches train presence, debounces the loop and latches sub-highway requests.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE     = 4,
  parameter int TRAIN_HOLD   = 10,
  parameter int STUCK_CYCLES = 200,
  parameter int CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_raw_train,
  input  logic             i_raw_sub_veh,
  input  logic             i_sub_green_in,
  output logic             o_sen_train,
  output logic             o_sen_sub_highway,
  output logic             o_loop_fault,
  output logic [CNT_W-1:0] o_veh_count
);

  localparam int HOLD_W = (TRAIN_HOLD > 0) ? $clog2(TRAIN_HOLD + 1) : 1;
  localparam int DEB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int STK_W  = $clog2(STUCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVING = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  logic              r_train_meta, r_s_train;
  logic              r_veh_meta, r_s_veh;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic              r_veh_f;
  logic [STK_W-1:0]  r_stuck_cnt;
  logic [CNT_W-1:0]  r_veh_count;
  logic              r_pend;
  state_t            r_state;

  logic              w_veh_mismatch;
  logic              w_deb_done;
  logic              w_veh_f_next;
  logic              w_arr;
  logic              w_stuck;
  logic              w_pend_next;
  state_t            w_state_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_train_meta <= 1'b0;
      r_s_train    <= 1'b0;
      r_veh_meta   <= 1'b0;
      r_s_veh      <= 1'b0;
    end else begin
      r_train_meta <= i_raw_train;
      r_s_train    <= r_train_meta;
      r_veh_meta   <= i_raw_sub_veh;
      r_s_veh      <= r_veh_meta;
    end
  end

  // Train presence is stretched rather than filtered so assertion is never delayed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_s_train) begin
      r_hold_cnt <= HOLD_W'(TRAIN_HOLD);
    end else if (r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  assign o_sen_train = r_s_train | (r_hold_cnt != '0);

  assign w_veh_mismatch = (r_s_veh != r_veh_f);
  assign w_deb_done     = w_veh_mismatch && (r_deb_cnt == DEB_W'(DEBOUNCE - 1));
  assign w_veh_f_next   = w_deb_done ? r_s_veh : r_veh_f;
  assign w_arr          = w_deb_done && r_s_veh;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_deb_cnt <= '0;
      r_veh_f   <= 1'b0;
    end else if (w_deb_done) begin
      r_deb_cnt <= '0;
      r_veh_f   <= r_s_veh;
    end else if (w_veh_mismatch) begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end else begin
      r_deb_cnt <= '0;
    end
  end

  // Stuck is a one-edge event (count stepping onto the limit) so FAULT can still be left.
  assign w_stuck = r_veh_f && (r_stuck_cnt == STK_W'(STUCK_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stuck_cnt <= '0;
    end else if (!r_veh_f) begin
      r_stuck_cnt <= '0;
    end else if (r_stuck_cnt != STK_W'(STUCK_CYCLES)) begin
      r_stuck_cnt <= r_stuck_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_veh_count <= '0;
    end else if (w_arr && (r_veh_count != {CNT_W{1'b1}})) begin
      r_veh_count <= r_veh_count + 1'b1;
    end
  end

  assign o_veh_count = r_veh_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend;
    if (w_stuck) begin
      w_state_next = ST_FAULT;
      w_pend_next  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arr) w_state_next = ST_REQ;
        end
        ST_REQ: begin
          if (i_sub_green_in) begin
            w_state_next = ST_SERVING;
            w_pend_next  = w_arr;
          end
        end
        ST_SERVING: begin
          if (!i_sub_green_in) begin
            w_state_next = (r_pend || w_arr) ? ST_REQ : ST_IDLE;
            w_pend_next  = 1'b0;
          end else if (w_arr) begin
            w_pend_next = 1'b1;
          end
        end
        ST_FAULT: begin
          if (!w_veh_f_next) begin
            w_state_next = ST_IDLE;
            w_pend_next  = 1'b0;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_pend_next  = 1'b0;
        end
      endcase
    end
  end

  assign o_sen_sub_highway = (r_state == ST_REQ);
  assign o_loop_fault      = (r_state == ST_FAULT);

endmodule
